pipeline_hazard_scoreboard: RTL and testbench



---
 rtl/pipeline_hazard_scoreboard.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_scoreboard.sv
// pipeline_hazard_scoreboard: decode-side hazard detection and EX forwarding-select controller.
//
// Tracks every register-writing instruction past decode in a DEPTH-entry shift
// register (entry 0 = EX, entry DEPTH-1 = WB). Stalls decode when an operand's
// youngest producer cannot be forwarded in time, registers the forwarding
// selects for the instruction entering EX, and squashes younger in-flight
// entries on a branch/jump redirect.
//
// Optional build macro: HAZARD_PERF_EN enables the saturating stall/redirect
// performance counters; without it both counter ports are tied to zero.
//
// Ports:
//   clock, reset            single rising-edge clock, synchronous active-high reset
//   id_valid                decode stage holds a real instruction
//   id_rs_addr, id_rt_addr  source operand addresses
//   id_uses_rs, id_uses_rt  operand is actually read
//   id_writes_reg           decode instruction writes a register
//   id_write_addr           destination register
//   id_is_load              result comes from data memory
//   redirect                taken branch/jump resolved this cycle
//   redirect_stage          entry index of the redirecting instruction
//   id_stall                hold PC and IF/ID, bubble into ID/EX
//   flush_id                discard the decode instruction
//   ex_fwd_rs_sel/rt_sel    0 = register file, n = value from entry n-1
//   stall_count             cycles with id_stall (HAZARD_PERF_EN)
//   redirect_count          cycles with redirect (HAZARD_PERF_EN)
module pipeline_hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    localparam int FWD_W     = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_writes_reg,
    input  logic [ADDR_W-1:0] id_write_addr,
    input  logic              id_is_load,
    input  logic              redirect,
    input  logic [FWD_W-1:0]  redirect_stage,
    output logic              id_stall,
    output logic              flush_id,
    output logic [FWD_W-1:0]  ex_fwd_rs_sel,
    output logic [FWD_W-1:0]  ex_fwd_rt_sel,
    output logic [31:0]       stall_count,
    output logic [31:0]       redirect_count
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             load_q, load_d;
    logic [DEPTH-1:0][ADDR_W-1:0] dest_q, dest_d;
    logic [FWD_W-1:0]             rs_sel_q, rs_sel_d;
    logic [FWD_W-1:0]             rt_sel_q, rt_sel_d;

    logic [1:0]                   use_op;
    logic [1:0][ADDR_W-1:0]       src_op;
    logic [1:0]                   haz;
    logic [1:0][FWD_W-1:0]        sel;

    // Per-operand lookup: scan oldest to youngest so the youngest producer wins.
    always_comb begin : lookup
        logic hit;
        int   kk;
        int   rdy;
        use_op = {id_uses_rt, id_uses_rs};
        src_op = {id_rt_addr, id_rs_addr};
        haz    = '0;
        sel    = '0;
        for (int o = 0; o < 2; o++) begin
            hit = 1'b0;
            kk  = 0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (use_op[o] && src_op[o] != '0 && valid_q[k] && dest_q[k] == src_op[o]) begin
                    hit = 1'b1;
                    kk  = k;
                end
            end
            rdy    = load_q[kk] ? LOAD_READY : ALU_READY;
            // Producer will sit at entry kk+1 when the consumer is in EX.
            haz[o] = hit && (kk + 1 < rdy);
            // Past WB the register file's write-to-read bypass supplies the value.
            sel[o] = (hit && kk + 1 <= DEPTH - 1) ? FWD_W'(kk + 2) : '0;
        end
    end

    always_comb begin
        id_stall   = (|haz) & id_valid & ~redirect;
        flush_id   = redirect;
        valid_d[0] = id_valid & id_writes_reg & (id_write_addr != '0) & ~id_stall & ~redirect;
        dest_d[0]  = id_write_addr;
        load_d[0]  = id_is_load;
        for (int k = 1; k < DEPTH; k++) begin
            // Entries younger than the redirecting instruction are squashed while shifting.
            valid_d[k] = valid_q[k-1] & ~(redirect & (FWD_W'(k - 1) < redirect_stage));
            dest_d[k]  = dest_q[k-1];
            load_d[k]  = load_q[k-1];
        end
        rs_sel_d = (id_stall | redirect) ? '0 : sel[0];
        rt_sel_d = (id_stall | redirect) ? '0 : sel[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= '0;
            load_q   <= '0;
            dest_q   <= '0;
            rs_sel_q <= '0;
            rt_sel_q <= '0;
        end else begin
            valid_q  <= valid_d;
            load_q   <= load_d;
            dest_q   <= dest_d;
            rs_sel_q <= rs_sel_d;
            rt_sel_q <= rt_sel_d;
        end
    end

    assign ex_fwd_rs_sel = rs_sel_q;
    assign ex_fwd_rt_sel = rt_sel_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = (id_stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        redir_cnt_d = (redirect && redir_cnt_q != '1) ? redir_cnt_q + 32'd1 : redir_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign stall_count    = stall_cnt_q;
    assign redirect_count = redir_cnt_q;
`else
    assign stall_count    = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// tb_pipeline_hazard_scoreboard: directed checks of the hazard scoreboard at two depths.
module tb_pipeline_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults (DEPTH=3, ALU_READY=1, LOAD_READY=2)
    logic       v, urs, urt, wr, ld, red;
    logic [4:0] rs, rt, wa;
    logic [1:0] rstg;
    logic       stall, flush;
    logic [1:0] srs, srt;
    logic [31:0] scnt, rcnt;

    // Instance B: DEPTH=5, ALU_READY=1, LOAD_READY=3
    logic       b_v, b_urs, b_urt, b_wr, b_ld, b_red;
    logic [4:0] b_rs, b_rt, b_wa;
    logic [2:0] b_rstg;
    logic       b_stall, b_flush;
    logic [2:0] b_srs, b_srt;
    logic [31:0] b_scnt, b_rcnt;

    int total = 0;
    int bad = 0;

    pipeline_hazard_scoreboard dut_a (
        .clock(clk), .reset(rst), .id_valid(v), .id_rs_addr(rs), .id_rt_addr(rt),
        .id_uses_rs(urs), .id_uses_rt(urt), .id_writes_reg(wr), .id_write_addr(wa),
        .id_is_load(ld), .redirect(red), .redirect_stage(rstg), .id_stall(stall),
        .flush_id(flush), .ex_fwd_rs_sel(srs), .ex_fwd_rt_sel(srt),
        .stall_count(scnt), .redirect_count(rcnt)
    );

    pipeline_hazard_scoreboard #(.DEPTH(5), .ALU_READY(1), .LOAD_READY(3)) dut_b (
        .clock(clk), .reset(rst_b), .id_valid(b_v), .id_rs_addr(b_rs), .id_rt_addr(b_rt),
        .id_uses_rs(b_urs), .id_uses_rt(b_urt), .id_writes_reg(b_wr), .id_write_addr(b_wa),
        .id_is_load(b_ld), .redirect(b_red), .redirect_stage(b_rstg), .id_stall(b_stall),
        .flush_id(b_flush), .ex_fwd_rs_sel(b_srs), .ex_fwd_rt_sel(b_srt),
        .stall_count(b_scnt), .redirect_count(b_rcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic vv, input logic [4:0] s, input logic [4:0] t,
                         input logic us, input logic ut, input logic ww, input logic [4:0] w,
                         input logic l, input logic rr, input logic [1:0] st);
        v = vv; rs = s; rt = t; urs = us; urt = ut; wr = ww; wa = w; ld = l; red = rr; rstg = st;
        #1;
    endtask

    task automatic set_b(input logic vv, input logic [4:0] s, input logic [4:0] t,
                         input logic us, input logic ut, input logic ww, input logic [4:0] w,
                         input logic l, input logic rr, input logic [2:0] st);
        b_v = vv; b_rs = s; b_rt = t; b_urs = us; b_urt = ut; b_wr = ww; b_wa = w;
        b_ld = l; b_red = rr; b_rstg = st;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        rst = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_rs_sel", 32'(srs), 0);
        chk("rst_rt_sel", 32'(srt), 0);
        chk("rst_stall_cnt", scnt, 0);
        chk("rst_redir_cnt", rcnt, 0);
        chk("b_rst_stall", 32'(b_stall), 0);

        // ALU chain: add $3<-$1,$2 ; sub $4<-$3,$5 ; or $6<-$3,$0 ; and $7<-$3,$4
        set_a(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        chk("add_stall", 32'(stall), 0);
        tick;
        chk("add_rs_sel", 32'(srs), 0);
        set_a(1, 3, 5, 1, 1, 1, 4, 0, 0, 0);
        chk("alu_alu_stall", 32'(stall), 0);
        tick;
        chk("alu_fwd_k0", 32'(srs), 2);
        chk("alu_fwd_rt_none", 32'(srt), 0);
        set_a(1, 3, 0, 1, 1, 1, 6, 0, 0, 0);
        tick;
        chk("alu_fwd_k1", 32'(srs), 3);
        chk("r0_read_sel", 32'(srt), 0);
        set_a(1, 3, 4, 1, 1, 1, 7, 0, 0, 0);
        chk("retire_stall", 32'(stall), 0);
        tick;
        chk("retired_sel", 32'(srs), 0);
        chk("rt_k1_sel", 32'(srt), 3);

        // Load-use: lw $8 ; add $9<-$8,$8 -> one bubble
        set_a(1, 1, 0, 1, 0, 1, 8, 1, 0, 0);
        tick;
        set_a(1, 8, 8, 1, 1, 1, 9, 0, 0, 0);
        chk("lu_stall", 32'(stall), 1);
        chk("lu_flush", 32'(flush), 0);
        tick;
        chk("lu_bubble_rs", 32'(srs), 0);
        chk("lu_stall_once", 32'(stall), 0);
        tick;
        chk("lu_fwd_rs", 32'(srs), 3);
        chk("lu_fwd_rt", 32'(srt), 3);

        // Register 0 never hazards
        set_a(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        tick;
        set_a(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        chk("r0_stall", 32'(stall), 0);
        tick;
        chk("r0_rs_sel", 32'(srs), 0);
        chk("r0_rt_sel", 32'(srt), 0);

        // Redirect during pending load-use: lw $10 squashed
        set_a(1, 1, 0, 1, 0, 1, 10, 1, 0, 0);
        tick;
        set_a(1, 10, 2, 1, 1, 1, 11, 0, 1, 1);
        chk("redir_stall", 32'(stall), 0);
        chk("redir_flush", 32'(flush), 1);
        tick;
        chk("redir_sel", 32'(srs), 0);
        set_a(1, 10, 10, 1, 1, 1, 12, 0, 0, 0);
        chk("post_redir_stall", 32'(stall), 0);
        chk("post_redir_flush", 32'(flush), 0);
        tick;
        chk("post_redir_rs", 32'(srs), 0);
        chk("post_redir_rt", 32'(srt), 0);

        // Two producers of $12: youngest wins
        set_a(1, 5, 0, 1, 0, 1, 12, 0, 0, 0);
        tick;
        set_a(1, 12, 0, 1, 0, 0, 0, 0, 0, 0);
        tick;
        chk("youngest_wins", 32'(srs), 2);
        set_a(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("redir2_flush", 32'(flush), 1);
        tick;

        // rt-only load-use; rs address matches but is not read
        set_a(1, 0, 0, 0, 0, 1, 15, 1, 0, 0);
        tick;
        set_a(1, 15, 15, 0, 1, 0, 0, 0, 0, 0);
        chk("rt_lu_stall", 32'(stall), 1);
        tick;
        chk("rt_lu_stall_once", 32'(stall), 0);
        tick;
        chk("rt_lu_fwd", 32'(srt), 3);
        chk("unused_rs_sel", 32'(srs), 0);

        // Third stall, then counters
        set_a(1, 0, 0, 0, 0, 1, 16, 1, 0, 0);
        tick;
        set_a(1, 16, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("lu3_stall", 32'(stall), 1);
        tick;
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt", scnt, 3);
        chk("perf_redir_cnt", rcnt, 2);
`else
        chk("perf_stall_off", scnt, 0);
        chk("perf_redir_off", rcnt, 0);
`endif
        set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_a(1, 16, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst2_stall_cnt", scnt, 0);
        chk("rst2_redir_cnt", rcnt, 0);
        chk("rst2_stall", 32'(stall), 0);

        // DEPTH=5, LOAD_READY=3: load-use stalls two cycles
        set_b(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
        tick;
        set_b(1, 8, 0, 1, 0, 1, 9, 0, 0, 0);
        chk("b_lu_stall1", 32'(b_stall), 1);
        tick;
        chk("b_lu_stall2", 32'(b_stall), 1);
        tick;
        chk("b_lu_stall_end", 32'(b_stall), 0);
        tick;
        chk("b_lu_fwd", 32'(b_srs), 4);

        // Redirect at stage 1: entry 0 squashed, entry 1 survives
        set_b(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        tick;
        set_b(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("b_redir_flush", 32'(b_flush), 1);
        chk("b_redir_stall", 32'(b_stall), 0);
        tick;
        set_b(1, 9, 10, 1, 1, 0, 0, 0, 0, 0);
        chk("b_survivor_stall", 32'(b_stall), 0);
        tick;
        chk("b_survivor_sel", 32'(b_srs), 4);
        chk("b_squashed_sel", 32'(b_srt), 0);

        // Reset in the middle of a two-cycle stall
        set_b(1, 0, 0, 0, 0, 1, 20, 1, 0, 0);
        tick;
        set_b(1, 20, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("b_mid_stall1", 32'(b_stall), 1);
        tick;
        chk("b_mid_stall2", 32'(b_stall), 1);
        rst_b = 1'b1;
        tick;
        rst_b = 1'b0;
        #1;
        chk("b_rst_mid_stall", 32'(b_stall), 0);
        tick;
        chk("b_rst_mid_sel", 32'(b_srs), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
